// File: rtl/logic_slice_sequencer.sv
// ============================================================================
// logic_slice_sequencer: 32-bit AND/OR/XOR/NOR via one shared SLICE-bit slice,
// LSB nibble first; optional zero flag under LOGIC_SEQ_ZERO_FLAG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module logic_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic             busy_o
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero_o
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $error("logic_slice_sequencer: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_valid_q, done_valid_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  logic             nonzero_q, nonzero_d;
  logic             zero_q, zero_d;
`endif

  int unsigned      base;
  logic [SLICE-1:0] slice_a, slice_b, slice_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      done_valid_q <= 1'b0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      nonzero_q    <= 1'b0;
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      done_valid_q <= done_valid_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      nonzero_q    <= nonzero_d;
      zero_q       <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    done_valid_d = done_valid_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    nonzero_d    = nonzero_q;
    zero_d       = zero_q;
`endif

    // The single shared slice: operands selected by the beat counter.
    base    = SLICE * 32'(cnt_q);
    slice_a = a_q[base +: SLICE];
    slice_b = b_q[base +: SLICE];
    case (op_q)
      2'b00:   slice_r = slice_a & slice_b;
      2'b01:   slice_r = slice_a | slice_b;
      2'b10:   slice_r = slice_a ^ slice_b;
      default: slice_r = ~(slice_a | slice_b);
    endcase

    case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          op_d      = op_i;
          a_d       = in1_i;
          b_d       = in2_i;
          result_d  = '0;
          cnt_d     = '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          nonzero_d = 1'b0;
`endif
          state_d   = BUSY;
        end
      end
      BUSY: begin
        result_d[base +: SLICE] = slice_r;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        nonzero_d = nonzero_q | (|slice_r);
`endif
        if (cnt_q == LAST_CNT) begin
          state_d      = DONE;
          done_valid_d = 1'b1;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          zero_d       = ~(nonzero_q | (|slice_r));
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d      = IDLE;
          done_valid_d = 1'b0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          zero_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d      = IDLE;
        done_valid_d = 1'b0;
      end
    endcase
  end

  assign start_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q == BUSY) || (state_q == DONE);
  assign result_o      = result_q;
  assign done_valid_o  = done_valid_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  assign zero_o        = zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_slice_sequencer.sv
// Bench for logic_slice_sequencer: scoreboard of expected results checked by a
// negedge monitor against a phase/beat-count protocol model.
`default_nettype none

module tb_logic_slice_sequencer;

  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1, in2;
  logic [WIDTH-1:0] result;
  logic             done_valid;
  logic             done_ready;
  logic             busy;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
  logic             zero;
`endif

  logic_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid_i(start_valid),
    .start_ready_o(start_ready),
    .op_i         (op),
    .in1_i        (in1),
    .in2_i        (in2),
    .result_o     (result),
    .done_valid_o (done_valid),
    .done_ready_i (done_ready),
    .busy_o       (busy)
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    ,
    .zero_o       (zero)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  int  m_phase = 0;  // 0 idle, 1 computing, 2 result offered
  int  m_beats = 0;  // beats already written in the current operation
  bit  dr_force = 1'b0;
  bit  dr_val   = 1'b0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] beat_mask(input int beats);
    logic [WIDTH-1:0] one;
    one = 1;
    if (beats >= N) return '1;
    return (one << (beats * SLICE)) - 1;
  endfunction

  // Protocol model: acceptance, N beats, then result held until taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_beats = 0;
    end else begin
      case (m_phase)
        0: if (start_valid) begin m_phase = 1; m_beats = 0; end
        1: begin
          m_beats++;
          if (m_beats == N) m_phase = 2;
        end
        default: if (done_ready) m_phase = 0;
      endcase
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("start_ready", start_ready, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("done_valid", done_valid, m_phase == 2);
      if (m_phase != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got empty queue expected an entry at %0t", $time);
        end else if (m_phase == 1) begin
          chk("partial_result", result, exp_q[0] & beat_mask(m_beats));
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          chk("zero_busy", zero, 0);
`endif
        end else begin
          if (done_ready) chk("result_taken", result, exp_q[0]);
          else            chk("result_hold", result, exp_q[0]);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
          chk("zero_done", zero, exp_q[0] == '0);
`endif
          if (done_ready) void'(exp_q.pop_front());
        end
      end else begin
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        chk("zero_idle", zero, 0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_phase != 0) begin
      start_valid = 1'($urandom % 2);
      in1 = $urandom;
      in2 = $urandom;
      op  = 2'($urandom % 4);
    end else begin
      start_valid = 1'b0;
    end
    done_ready = dr_force ? dr_val : (($urandom % 3) != 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_phase != 0 && n < 200) begin tick(); n++; end
    if (m_phase != 0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got phase %0d expected 0", m_phase);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    wait_idle();
    op = o; in1 = a; in2 = b;
    start_valid = 1'b1;
    exp_q.push_back(ref_op(o, a, b));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start_valid = 1'($urandom % 2);
    op = 2'($urandom % 4); in1 = $urandom; in2 = $urandom;
    done_ready = 1'($urandom % 2);
    repeat (3) begin
      @(posedge clk); #1;
      start_valid = 1'($urandom % 2); in1 = $urandom; in2 = $urandom;
    end
    chk("reset_result", result, '0);
    chk("reset_done_valid", done_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_start_ready", start_ready, 1);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    chk("reset_zero", zero, 0);
`endif
    start_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    issue(2'b11, 32'hF0F0_0000, 32'h0F0F_0000);   // NOR -> 0x0000FFFF
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // XOR -> 0, zero flag
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);   // bit arrives on last beat
    wait_idle();

    // Backpressure: result offered and held while a new start is ignored
    dr_force = 1'b1; dr_val = 1'b0; done_ready = 1'b0;
    issue(2'b01, 32'h1234_0000, 32'h0000_5678);
    for (int i = 0; i < 40 && m_phase != 2; i++) tick();
    repeat (5) begin tick(); start_valid = 1'b1; end
    dr_val = 1'b1; done_ready = 1'b1;
    tick();
    dr_force = 1'b0;
    issue(2'b10, 32'hDEAD_BEEF, 32'h0F0F_F0F0);

    // Operand isolation
    issue(2'b00, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    repeat (N) begin tick(); in1 = '0; op = 2'b11; end
    wait_idle();

    // Reset in the middle of an operation
    issue(2'($urandom % 4), $urandom, $urandom);
    for (int i = 0; i < 40 && !(m_phase == 1 && m_beats == 4); i++) tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_result", result, '0);
    chk("midrst_done_valid", done_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_start_ready", start_ready, 1);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    chk("midrst_zero", zero, 0);
`endif
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    issue(2'b00, 32'hAAAA_AAAA, 32'hFFFF_0000);

    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom % 4), $urandom, $urandom);
      if (($urandom % 4) == 0) tick();
    end
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_slice_sequencer.md
# logic_slice_sequencer

Multi-cycle controller that computes a 32-bit bitwise logic operation (AND/OR/XOR/NOR) by driving a single shared 4-bit logic slice eight times, least-significant nibble first. It sits beside the ALU as an area-reduced logic path. It accepts operands through a valid/ready start handshake, assembles the result in an internal register, and returns it through a valid/ready done handshake.

## Interface
- `WIDTH`, default 32: operand and result width. It must be an integer multiple of `SLICE`; any other value is an elaboration error.
- `SLICE`, default 4: bits processed per beat. The beat count is N = WIDTH/SLICE (8 by default).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_valid`  in  1  requester presents an operation.
- `start_ready`  out  1  block can accept an operation; equal to (state == IDLE).
- `op`  in  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
- `in1`, `in2`  in  WIDTH  operands; sampled only at acceptance.
- `result`  out  WIDTH  result register; meaningful only while `done_valid` = 1.
- `done_valid`  out  1  result available.
- `done_ready`  in  1  consumer takes the result.
- `busy`  out  1  high in BUSY and DONE.
- `zero`  out  1  result is all-zero; exists only with `LOGIC_SEQ_ZERO_FLAG_EN`.

## Operation
The FSM has three states: IDLE, BUSY and DONE.

- **IDLE**
  - `start_ready` = 1.
  - When `start_valid` && `start_ready`, the block latches `op`, `in1` and `in2`, clears `result` to 0, sets beat counter `cnt` to 0, and moves to BUSY.
- **BUSY**
  - Each cycle computes `op` on latched bits [SLICE*cnt +: SLICE] and writes them into the same bits of `result`.
  - `cnt` increments each cycle.
  - After the beat with `cnt` = N-1 is written, the FSM moves to DONE.
  - `cnt` never wraps inside an operation.
- **DONE**
  - `done_valid` = 1 and `result` is held stable.
  - When `done_ready` = 1, the FSM moves to IDLE and `done_valid` drops at that same edge.

Boundary rules:
- `start_valid` in BUSY or DONE is ignored, with no buffering.
- Changes on `in1`, `in2` or `op` after acceptance have no effect.
- `done_ready` outside DONE is ignored.
- Asserting `rst_n` low in any state immediately forces the reset values below. The partial operation is discarded, and the next accepted operation behaves normally.
- Bits of `result` not yet written in BUSY read 0. Consumers must not sample `result` outside DONE.

Reset values:
- state IDLE, `cnt` 0.
- `result` 0, `done_valid` 0, `busy` 0, `zero` 0.
- `start_ready` 1, since it follows the IDLE state.

## Timing
- Acceptance happens at edge E0. Beats are written at edges E1..EN. `done_valid` is high in the cycle after EN, so latency is N cycles (8 by default) from acceptance to `done_valid`.
- Minimum issue interval is N+2 cycles (10 by default): the accept cycle, N BUSY cycles, and one DONE cycle with `done_ready` already high.
- DONE→IDLE and the next acceptance cannot occur in the same cycle; there is always one IDLE cycle between operations.
- Outputs are registered, except `start_ready` and `busy`, which are direct decodes of the state register.

## Configuration
- `LOGIC_SEQ_ZERO_FLAG_EN` defined:
  - A `zero` output port exists, backed by a sticky "nonzero" register.
  - The register clears at acceptance and is set by OR-reduction of each written beat.
  - `zero` = ~nonzero while in DONE, and 0 in all other states.
  - No extra latency.
- `LOGIC_SEQ_ZERO_FLAG_EN` undefined: the `zero` port and its register are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with random inputs. Required: `result` = 0, `done_valid` = 0, `busy` = 0, `start_ready` = 1, `zero` = 0.
- **NOR:** `in1` = 0xF0F0_0000, `in2` = 0x0F0F_0000, `op` = 11. Required:
  - `result` = 0x0000_FFFF.
  - `done_valid` rises exactly 8 cycles after the acceptance edge.
  - `busy` is high for 8 BUSY cycles plus the DONE cycles.
- **XOR with zero flag** (macro defined): `in1` = `in2` = 0xFFFF_FFFF, `op` = 10. Required: `result` = 0, `zero` = 1 in DONE. Then run AND of 0x8000_0000 with 0xFFFF_FFFF. Required: `result` = 0x8000_0000, `zero` = 0, with the only set bit arriving on the last beat.
- **Backpressure:** OR of 0x1234_0000 and 0x0000_5678. Required:
  - With `done_ready` held low for 5 cycles: `result` stays 0x1234_5678, `done_valid` stays 1, and a concurrent `start_valid` is not accepted.
  - After `done_ready` pulses: IDLE for one cycle, then the new start is accepted.
- **Operand isolation:** start AND of 0xFFFF_FFFF and 0x0F0F_0F0F, then drive `in1` = 0, `op` = 11 during BUSY. Required: `result` = 0x0F0F_0F0F.
- **Reset mid-operation:** assert `rst_n` low at `cnt` = 4. Required: all outputs return to reset values asynchronously, before the next edge. Then start AND of 0xAAAA_AAAA and 0xFFFF_0000. Required: `result` = 0xAAAA_0000 after 8 cycles.
